// File: rtl/sys_ctrl_rx_decoder.sv
// sys_ctrl_rx_decoder
//   Command-frame decoder fed by the bus synchronizer. One byte arrives per
//   RX_D_VLD strobe; multi-byte frames are parsed into register-file
//   write/read strobes and ALU start strobes. Malformed, stray and stalled
//   frames raise cmd_err.
// Ports
//   CLK, RST          clock, asynchronous active-low reset
//   RX_D, RX_D_VLD    synced byte and its 1-cycle valid strobe
//   RdData_Valid      register-file read completion
//   ALU_OUT_VLD       ALU result completion
//   Address, WrData   register-file address / write data (held between strobes)
//   WrEn, RdEn        1-cycle register-file strobes
//   ALU_EN, ALU_FUN   1-cycle ALU start strobe, function code (held)
//   CLK_EN            ALU clock-gate enable (level)
//   frame_done        1-cycle strobe, frame completed
//   cmd_err           1-cycle strobe, bad opcode / stray byte / timeout
//   busy              high whenever a frame is in progress
module sys_ctrl_rx_decoder #(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned FUN_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [BUS_WIDTH-1:0]  RX_D,
  input  logic                  RX_D_VLD,
  input  logic                  RdData_Valid,
  input  logic                  ALU_OUT_VLD,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [BUS_WIDTH-1:0]  WrData,
  output logic                  ALU_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  CLK_EN,
  output logic                  frame_done,
  output logic                  cmd_err,
  output logic                  busy
);

  localparam logic [BUS_WIDTH-1:0] OP_WR      = BUS_WIDTH'(8'hAA);
  localparam logic [BUS_WIDTH-1:0] OP_RD      = BUS_WIDTH'(8'hBB);
  localparam logic [BUS_WIDTH-1:0] OP_ALU     = BUS_WIDTH'(8'hCC);
  localparam logic [BUS_WIDTH-1:0] OP_ALU_NOP = BUS_WIDTH'(8'hDD);

  localparam int unsigned       TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]     T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]     T_MAX  = TW'(TIMEOUT_CYC);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_OPA,
    S_OPB,
    S_FUN,
    S_ALU_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           tcnt_q;
  logic [ADDR_WIDTH-1:0]   addr_lat_q, addr_lat_d;
  logic                    completion, timeout;

  logic                    wr_en_d, rd_en_d, alu_en_d, frame_done_d, cmd_err_d;
  logic [ADDR_WIDTH-1:0]   address_d;
  logic [BUS_WIDTH-1:0]    wr_data_d;
  logic [FUN_WIDTH-1:0]    alu_fun_d;
  logic                    is_opcode;

  assign is_opcode = (RX_D == OP_WR) || (RX_D == OP_RD) ||
                     (RX_D == OP_ALU) || (RX_D == OP_ALU_NOP);

  // State register and inter-byte idle counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || RX_D_VLD || (state_q == S_IDLE))
        tcnt_q <= '0;
      else if (tcnt_q != T_MAX)
        tcnt_q <= tcnt_q + TW'(1);
    end
  end

  // Next-state logic. A completion beats a coincident stray byte; a byte
  // (stray or not) restarts the idle window, so timeout needs a quiet cycle.
  always_comb begin
    completion = ((state_q == S_RD_WAIT)  && RdData_Valid) ||
                 ((state_q == S_ALU_WAIT) && ALU_OUT_VLD);
    timeout    = (state_q != S_IDLE) && !RX_D_VLD && !completion &&
                 (tcnt_q == T_LAST);
    state_d    = state_q;
    if (timeout) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (RX_D_VLD) begin
            if (RX_D == OP_WR)           state_d = S_WR_ADDR;
            else if (RX_D == OP_RD)      state_d = S_RD_ADDR;
            else if (RX_D == OP_ALU)     state_d = S_OPA;
            else if (RX_D == OP_ALU_NOP) state_d = S_FUN;
          end
        end
        S_WR_ADDR:  if (RX_D_VLD) state_d = S_WR_DATA;
        S_WR_DATA:  if (RX_D_VLD) state_d = S_IDLE;
        S_RD_ADDR:  if (RX_D_VLD) state_d = S_RD_WAIT;
        S_RD_WAIT:  if (completion) state_d = S_IDLE;
        S_OPA:      if (RX_D_VLD) state_d = S_OPB;
        S_OPB:      if (RX_D_VLD) state_d = S_FUN;
        S_FUN:      if (RX_D_VLD) state_d = S_ALU_WAIT;
        S_ALU_WAIT: if (completion) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    alu_en_d     = 1'b0;
    frame_done_d = completion;
    cmd_err_d    = timeout;
    address_d    = Address;
    wr_data_d    = WrData;
    alu_fun_d    = ALU_FUN;
    addr_lat_d   = addr_lat_q;
    unique case (state_q)
      S_IDLE: begin
        if (RX_D_VLD && !is_opcode) cmd_err_d = 1'b1;
      end
      S_WR_ADDR: begin
        if (RX_D_VLD) addr_lat_d = RX_D[ADDR_WIDTH-1:0];
      end
      S_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_en_d      = 1'b1;
          address_d    = addr_lat_q;
          wr_data_d    = RX_D;
          frame_done_d = 1'b1;
        end
      end
      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          rd_en_d   = 1'b1;
          address_d = RX_D[ADDR_WIDTH-1:0];
        end
      end
      S_OPA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(0);
          wr_data_d = RX_D;
        end
      end
      S_OPB: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(1);
          wr_data_d = RX_D;
        end
      end
      S_FUN: begin
        if (RX_D_VLD) begin
          alu_en_d  = 1'b1;
          alu_fun_d = RX_D[FUN_WIDTH-1:0];
        end
      end
      S_RD_WAIT, S_ALU_WAIT: begin
        if (RX_D_VLD) cmd_err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers; CLK_EN/busy are registered decodes of the next state
  // so they line up exactly with the state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Address    <= '0;
      WrEn       <= 1'b0;
      RdEn       <= 1'b0;
      WrData     <= '0;
      ALU_EN     <= 1'b0;
      ALU_FUN    <= '0;
      CLK_EN     <= 1'b0;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
      busy       <= 1'b0;
      addr_lat_q <= '0;
    end else begin
      Address    <= address_d;
      WrEn       <= wr_en_d;
      RdEn       <= rd_en_d;
      WrData     <= wr_data_d;
      ALU_EN     <= alu_en_d;
      ALU_FUN    <= alu_fun_d;
      CLK_EN     <= (state_d == S_FUN) || (state_d == S_ALU_WAIT);
      frame_done <= frame_done_d;
      cmd_err    <= cmd_err_d;
      busy       <= (state_d != S_IDLE);
      addr_lat_q <= addr_lat_d;
    end
  end

endmodule

// File: tb/tb_sys_ctrl_rx_decoder.sv
// tb_sys_ctrl_rx_decoder
//   Self-checking bench for sys_ctrl_rx_decoder: a vector table from reset,
//   directed multi-cycle sequences, and randomized traffic compared against
//   a frame-level reference model (byte queue per frame).
module tb_sys_ctrl_rx_decoder;

  localparam int T = 40;

  logic       CLK, RST;
  logic [7:0] RX_D;
  logic       RX_D_VLD, RdData_Valid, ALU_OUT_VLD;
  logic [3:0] Address;
  logic       WrEn, RdEn, ALU_EN, CLK_EN, frame_done, cmd_err, busy;
  logic [7:0] WrData;
  logic [3:0] ALU_FUN;

  sys_ctrl_rx_decoder #(
    .BUS_WIDTH  (8),
    .ADDR_WIDTH (4),
    .FUN_WIDTH  (4),
    .TIMEOUT_CYC(T)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_D        (RX_D),
    .RX_D_VLD    (RX_D_VLD),
    .RdData_Valid(RdData_Valid),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .Address     (Address),
    .WrEn        (WrEn),
    .RdEn        (RdEn),
    .WrData      (WrData),
    .ALU_EN      (ALU_EN),
    .ALU_FUN     (ALU_FUN),
    .CLK_EN      (CLK_EN),
    .frame_done  (frame_done),
    .cmd_err     (cmd_err),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: frame = queue of accepted bytes
  logic [7:0] fb[$];
  int         m_idle;
  logic       m_wr, m_rd, m_alu, m_done, m_err, m_busy, m_clken;
  logic [3:0] m_addr, m_fun;
  logic [7:0] m_wdata;

  function automatic int flen(input logic [7:0] op);
    case (op)
      8'hAA:   return 3;
      8'hCC:   return 4;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    fb.delete();
    m_idle = 0;
    {m_wr, m_rd, m_alu, m_done, m_err, m_busy, m_clken} = '0;
    m_addr = '0; m_fun = '0; m_wdata = '0;
  endtask

  task automatic model_step(input logic vld, input logic [7:0] d, input logic rdv, input logic aluv);
    logic [7:0] b1;
    {m_wr, m_rd, m_alu, m_done, m_err} = '0;
    if (fb.size() == 0) begin
      if (vld) begin
        if (d inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) begin
          fb.push_back(d);
          m_idle = 0;
        end else m_err = 1'b1;
      end
    end else if (fb.size() == flen(fb[0])) begin
      if (vld) m_err = 1'b1;
      if ((fb[0] == 8'hBB && rdv) || (fb[0] != 8'hBB && aluv)) begin
        m_done = 1'b1;
        fb.delete();
        m_idle = 0;
      end else if (vld) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == T) begin m_err = 1'b1; fb.delete(); m_idle = 0; end
      end
    end else if (vld) begin
      fb.push_back(d);
      m_idle = 0;
      case (fb[0])
        8'hAA: if (fb.size() == 3) begin
          b1 = fb[1];
          m_wr = 1'b1; m_addr = b1[3:0]; m_wdata = d; m_done = 1'b1;
          fb.delete();
        end
        8'hBB: begin m_rd = 1'b1; m_addr = d[3:0]; end
        8'hCC: begin
          if (fb.size() == 2)      begin m_wr = 1'b1; m_addr = 4'd0; m_wdata = d; end
          else if (fb.size() == 3) begin m_wr = 1'b1; m_addr = 4'd1; m_wdata = d; end
          else                     begin m_alu = 1'b1; m_fun = d[3:0]; end
        end
        default: begin m_alu = 1'b1; m_fun = d[3:0]; end
      endcase
    end else begin
      m_idle++;
      if (m_idle == T) begin m_err = 1'b1; fb.delete(); m_idle = 0; end
    end
    m_busy  = (fb.size() != 0);
    m_clken = (fb.size() != 0) && ((fb[0] == 8'hDD) || (fb[0] == 8'hCC && fb.size() >= 3));
  endtask

  // ---------------- one clock of stimulus, model update and comparison
  int   n_wr, n_rd, n_alu, n_done, n_err;
  logic last_clken, clken_before_alu;

  task automatic clear_counts();
    n_wr = 0; n_rd = 0; n_alu = 0; n_done = 0; n_err = 0;
    clken_before_alu = 1'b0;
  endtask

  task automatic cycle(input logic vld, input logic [7:0] d, input logic rdv, input logic aluv);
    RX_D_VLD = vld; RX_D = d; RdData_Valid = rdv; ALU_OUT_VLD = aluv;
    @(posedge CLK);
    model_step(vld, d, rdv, aluv);
    @(negedge CLK);
    check("m_WrEn", WrEn, m_wr);
    check("m_RdEn", RdEn, m_rd);
    check("m_ALU_EN", ALU_EN, m_alu);
    check("m_frame_done", frame_done, m_done);
    check("m_cmd_err", cmd_err, m_err);
    check("m_busy", busy, m_busy);
    check("m_CLK_EN", CLK_EN, m_clken);
    check("m_Address", Address, m_addr);
    check("m_WrData", WrData, m_wdata);
    check("m_ALU_FUN", ALU_FUN, m_fun);
    if ((WrEn + RdEn + ALU_EN) > 1) check("strobe_exclusive", 1, 0);
    n_wr += WrEn; n_rd += RdEn; n_alu += ALU_EN; n_done += frame_done; n_err += cmd_err;
    if (ALU_EN) clken_before_alu = last_clken;
    last_clken = CLK_EN;
    RX_D_VLD = 1'b0; RdData_Valid = 1'b0; ALU_OUT_VLD = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic byte_in(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
  endtask

  // Asserted just after a falling edge; outputs must clear without a clock.
  task automatic do_reset();
    RST = 1'b0;
    #2;
    check("rst_Address", Address, 0);
    check("rst_WrData", WrData, 0);
    check("rst_ALU_FUN", ALU_FUN, 0);
    check("rst_strobes", {WrEn, RdEn, ALU_EN, frame_done, cmd_err}, 0);
    check("rst_CLK_EN", CLK_EN, 0);
    check("rst_busy", busy, 0);
    model_reset();
    last_clken = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // ---------------- vector table
  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic       rdv, aluv;
    logic       wr, rd, alu, done, err, bsy, clken;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [3:0] fun;
  } vec_t;

  vec_t tv[12];

  initial begin
    logic [7:0] ops[4];
    int got;
    ops[0] = 8'hAA; ops[1] = 8'hBB; ops[2] = 8'hCC; ops[3] = 8'hDD;

    //         vld   d      rdv   aluv  wr    rd    alu   done  err   busy  clken addr   wdata  fun
    tv[0]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 4'h0};
    tv[1]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 4'h0};
    tv[2]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 8'h3C, 4'h0};
    tv[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 8'h3C, 4'h0};
    tv[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 8'h3C, 4'h0};
    tv[5]  = '{1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 8'h3C, 4'h0};
    tv[6]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 8'h3C, 4'h2};
    tv[7]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 8'h3C, 4'h2};
    tv[8]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 8'h3C, 4'h2};
    tv[9]  = '{1'b1, 8'h1A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 8'h3C, 4'h2};
    tv[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 8'h3C, 4'h2};
    tv[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 8'h3C, 4'h2};

    RST = 1'b1; RX_D = '0; RX_D_VLD = 1'b0; RdData_Valid = 1'b0; ALU_OUT_VLD = 1'b0;
    last_clken = 1'b0;
    clear_counts();
    #3;
    do_reset();

    // table from reset state
    for (int i = 0; i < 12; i++) begin
      cycle(tv[i].vld, tv[i].d, tv[i].rdv, tv[i].aluv);
      check($sformatf("tv%0d_WrEn", i), WrEn, tv[i].wr);
      check($sformatf("tv%0d_RdEn", i), RdEn, tv[i].rd);
      check($sformatf("tv%0d_ALU_EN", i), ALU_EN, tv[i].alu);
      check($sformatf("tv%0d_frame_done", i), frame_done, tv[i].done);
      check($sformatf("tv%0d_cmd_err", i), cmd_err, tv[i].err);
      check($sformatf("tv%0d_busy", i), busy, tv[i].bsy);
      check($sformatf("tv%0d_CLK_EN", i), CLK_EN, tv[i].clken);
      check($sformatf("tv%0d_Address", i), Address, tv[i].addr);
      check($sformatf("tv%0d_WrData", i), WrData, tv[i].wdata);
      check($sformatf("tv%0d_ALU_FUN", i), ALU_FUN, tv[i].fun);
    end

    // write with 10-clock byte gaps
    clear_counts();
    byte_in(8'hAA); idle(9);
    byte_in(8'h05); idle(9);
    byte_in(8'h3C);
    check("gap_wr_count", n_wr, 1);
    check("gap_wr_done", frame_done, 1);
    check("gap_wr_addr", Address, 5);
    check("gap_wr_data", WrData, 8'h3C);
    check("gap_wr_busy", busy, 0);

    // read with RdData_Valid three clocks after the address byte
    clear_counts();
    byte_in(8'hBB); byte_in(8'h0F); idle(2);
    check("rd_not_done_early", n_done, 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("rd_count", n_rd, 1);
    check("rd_addr", Address, 4'hF);
    check("rd_done", frame_done, 1);

    // ALU with operands
    clear_counts();
    byte_in(8'hCC); idle(1);
    byte_in(8'h12);
    check("alu_opa_data", WrData, 8'h12);
    check("alu_opa_addr", Address, 0);
    idle(1);
    byte_in(8'h34);
    check("alu_opb_data", WrData, 8'h34);
    check("alu_opb_addr", Address, 1);
    idle(2);
    byte_in(8'h01);
    check("alu_fun", ALU_FUN, 1);
    check("alu_clken_before", clken_before_alu, 1);
    idle(3);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("alu_done", frame_done, 1);
    check("alu_wr_count", n_wr, 2);
    check("alu_en_count", n_alu, 1);
    idle(1);
    check("alu_clken_off", CLK_EN, 0);

    // timeout after a stalled write frame
    clear_counts();
    byte_in(8'hAA); byte_in(8'h05);
    got = -1;
    for (int i = 1; i <= 3 * T; i++) begin
      idle(1);
      if (cmd_err) begin got = i; break; end
    end
    check("timeout_cycles", got, T);
    check("timeout_busy", busy, 0);
    check("timeout_no_wr", n_wr, 0);

    // reset between the two operand bytes, then a clean write
    clear_counts();
    byte_in(8'hCC); byte_in(8'h12);
    do_reset();
    byte_in(8'hAA); byte_in(8'h01); byte_in(8'hFF);
    check("post_rst_wr", WrEn, 1);
    check("post_rst_addr", Address, 1);
    check("post_rst_data", WrData, 8'hFF);

    // randomized traffic: dense bytes, then sparse bytes to provoke timeouts
    for (int k = 0; k < 5000; k++) begin
      int unsigned p, r;
      logic [7:0] d;
      p = (k >= 2500 && k < 4000) ? 2 : 30;
      r = $urandom_range(9);
      d = (r < 6) ? ops[r % 4] : 8'($urandom_range(255));
      cycle($urandom_range(99) < p, d, $urandom_range(99) < 8, $urandom_range(99) < 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
